icache_ctrl: RTL

- Direct-mapped, read-only instruction cache between the fetch stage's instruction port (valid/addr in, rdata/ready out) and the memory-side refill port.
- Hits return one cycle after the request is sampled.
- Misses refill a whole line with a counted word burst, then respond.
- A flush input invalidates all lines, for fence.i.

---
 rtl/icache_pkg.sv | 41 ++++
 rtl/icache_if.sv | 24 ++
 rtl/icache_data_ram.sv | 26 ++
 rtl/icache_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINES    = 64;
  localparam int WORDS    = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [TAG_W-1:0]    tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    REFILL = 2'd2,
    FLUSH  = 2'd3
  } icache_state_t;

  function automatic offset_t addr_offset(input addr_t a);
    return a[OFFSET_W+1:2];
  endfunction

  function automatic index_t addr_index(input addr_t a);
    return a[OFFSET_W+2 +: INDEX_W];
  endfunction

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic addr_t line_base(input addr_t a);
    return {a[ADDR_W-1:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side request/response and memory-side refill signals of the instruction cache.
interface icache_if
  import icache_pkg::*;
;
  logic  valid;
  addr_t addr;
  logic  ready;
  data_t rdata;
  logic  flush;
  logic  mem_req;
  addr_t mem_addr;
  logic  mem_rvalid;
  data_t mem_rdata;

  modport slave (
    input  valid, addr, flush, mem_rvalid, mem_rdata,
    output ready, rdata, mem_req, mem_addr
  );

  modport master (
    output valid, addr, flush, mem_rvalid, mem_rdata,
    input  ready, rdata, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_data_ram.sv
// Cache data store: line/word addressed, synchronous write, combinational read.
module icache_data_ram
  import icache_pkg::*;
(
  input  logic    clk,
  input  logic    we_i,
  input  index_t  w_index_i,
  input  offset_t w_word_i,
  input  data_t   w_data_i,
  input  index_t  r_index_i,
  input  offset_t r_word_i,
  output data_t   r_data_o
);

  data_t mem_q [LINES*WORDS];

  // Refill beat write
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{w_index_i, w_word_i}] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[{r_index_i, r_word_i}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller with burst refill and deferred flush.
module icache_ctrl
  import icache_pkg::*;
(
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);

  icache_state_t    state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  tag_t             tag_q [LINES];
  addr_t            req_addr_q, req_addr_d;
  offset_t          cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             ready_q, ready_d;
  data_t            rdata_q, rdata_d;
  logic             mem_req_q, mem_req_d;
  addr_t            mem_addr_q, mem_addr_d;

  logic   tag_we_s;
  logic   ram_we_s;
  logic   hit_s;
  index_t req_idx_s;
  index_t cap_idx_s;
  data_t  ram_rdata_s;

  assign req_idx_s = addr_index(bus.addr);
  assign cap_idx_s = addr_index(req_addr_q);
  assign hit_s     = valid_q[req_idx_s] && (tag_q[req_idx_s] == addr_tag(bus.addr));

  icache_data_ram u_data_ram (
    .clk       (clk),
    .we_i      (ram_we_s),
    .w_index_i (cap_idx_s),
    .w_word_i  (cnt_q),
    .w_data_i  (bus.mem_rdata),
    .r_index_i (req_idx_s),
    .r_word_i  (addr_offset(bus.addr)),
    .r_data_o  (ram_rdata_s)
  );

  // Next-state, array updates and registered-output next values
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    req_addr_d   = req_addr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    tag_we_s     = 1'b0;
    ram_we_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = FLUSH;
        end else if (bus.valid && hit_s) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = ram_rdata_s;
        end else if (bus.valid) begin
          state_d    = REFILL;
          req_addr_d = bus.addr;
          mem_addr_d = line_base(bus.addr);
          mem_req_d  = 1'b1;
          cnt_d      = {OFFSET_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (flush_pend_q || bus.flush) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (bus.mem_rvalid) begin
          ram_we_s = 1'b1;
          cnt_d    = cnt_q + {{(OFFSET_W-1){1'b0}}, 1'b1};
          if (cnt_q == addr_offset(req_addr_q)) begin
            rdata_d = bus.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          if (cnt_q == offset_t'(WORDS-1)) begin
            valid_d[cap_idx_s] = 1'b1;
            tag_we_s           = 1'b1;
            mem_req_d          = 1'b0;
            ready_d            = 1'b1;
            state_d            = RESP;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      FLUSH: begin
        valid_d = {LINES{1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= {LINES{1'b0}};
      req_addr_q   <= {ADDR_W{1'b0}};
      cnt_q        <= {OFFSET_W{1'b0}};
      flush_pend_q <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= {DATA_W{1'b0}};
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Tag array, written when a refill completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= {TAG_W{1'b0}};
      end
    end else if (tag_we_s) begin
      tag_q[cap_idx_s] <= addr_tag(req_addr_q);
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

endmodule
